// File: rtl/image_display_pkg.sv
// Shared types and sizing helpers for the image display controller.
package image_display_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} cpu_state_t;

  function automatic int img_pixels(input int w, input int h);
    return w * h;
  endfunction

  function automatic int buf_w(input int nbuf);
    return (nbuf > 1) ? $clog2(nbuf) : 1;
  endfunction

endpackage

// File: rtl/idc_pixel_pipe.sv
// Scan-out side: video slot detection, buffer address forming and the
// two-stage pixel pipe that aligns pix_out/pix_valid with the memory latency.
module idc_pixel_pipe
  import image_display_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int NBUF   = 2,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int XY_W   = 10,
  parameter int ADDR_W = 18,
  localparam int BUF_W = buf_w(NBUF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_ce,
  input  logic                  pix_active,
  input  logic [XY_W-1:0]       pix_x,
  input  logic [XY_W-1:0]       pix_y,
  input  logic                  disp_enb,
  input  logic [BUF_W-1:0]      disp_src,
  input  logic [NBUF*PIX_W-1:0] mem_rdata,
  output logic                  vid_slot,
  output logic [ADDR_W-1:0]     vid_addr,
  output logic [PIX_W-1:0]      pix_out,
  output logic                  pix_valid
);

  logic             s1_ce;
  logic             s1_slot;
  logic             s1_active;
  logic [BUF_W-1:0] s1_src;

  assign vid_slot = pix_ce && pix_active && disp_enb &&
                    (32'(pix_x) < IMG_W) && (32'(pix_y) < IMG_H);
  assign vid_addr = ADDR_W'(32'(pix_y) * 32'(IMG_W) + 32'(pix_x));

  // Stage 1 tracks the slot while the buffer read is in flight; stage 2 picks the data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_ce     <= 1'b0;
      s1_slot   <= 1'b0;
      s1_active <= 1'b0;
      s1_src    <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      s1_ce     <= pix_ce;
      s1_slot   <= vid_slot;
      s1_active <= pix_active;
      s1_src    <= disp_src;
      if (s1_ce) begin
        pix_out   <= s1_slot ? mem_rdata[int'(s1_src) * PIX_W +: PIX_W] : '0;
        pix_valid <= s1_active;
      end
    end
  end

endmodule

// File: rtl/image_display_controller.sv
// Arbitrates NBUF single-port image buffers between VGA scan-out (priority) and a
// handshaked CPU port. Build option IDC_VSYNC_SWAP_EN defers display control to frame_start.
//   state  | meaning
//   IDLE   | waiting; CPU op issued on a request cycle that is not a video slot
//   ACCESS | op in flight; writes complete here with cpu_ready
//   RESP   | read data captured, cpu_ready pulses
module image_display_controller
  import image_display_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int NBUF   = 2,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int XY_W   = 10,
  parameter int ADDR_W = 18,
  localparam int BUF_W = buf_w(NBUF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_ce,
  input  logic                  pix_active,
  input  logic [XY_W-1:0]       pix_x,
  input  logic [XY_W-1:0]       pix_y,
  input  logic                  frame_start,
  input  logic                  ctrl_we,
  input  logic [BUF_W-1:0]      ctrl_src,
  input  logic                  ctrl_enb,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [BUF_W-1:0]      cpu_buf,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [PIX_W-1:0]      cpu_wdata,
  output logic                  cpu_ready,
  output logic [PIX_W-1:0]      cpu_rdata,
  output logic [NBUF-1:0]       mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [PIX_W-1:0]      mem_wdata,
  input  logic [NBUF*PIX_W-1:0] mem_rdata,
  output logic [PIX_W-1:0]      pix_out,
  output logic                  pix_valid
);

  localparam int IMG_PIX = img_pixels(IMG_W, IMG_H);

  cpu_state_t        state;
  logic              disp_enb;
  logic [BUF_W-1:0]  disp_src;
  logic              vid_slot;
  logic [ADDR_W-1:0] vid_addr;
  logic              src_ok;
  logic              cpu_ok;
  logic              cpu_issue;
  logic              op_we;
  logic              op_ok;
  logic [BUF_W-1:0]  op_buf;

  assign src_ok    = 32'(ctrl_src) < NBUF;
  assign cpu_ok    = (32'(cpu_buf) < NBUF) && (32'(cpu_addr) < IMG_PIX);
  // Gated by reset so a request held through reset cannot reach the buffers.
  assign cpu_issue = (state == IDLE) && cpu_req && !vid_slot && reset;

`ifdef IDC_VSYNC_SWAP_EN
  logic             pend_enb;
  logic [BUF_W-1:0] pend_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_enb <= 1'b0;
      pend_src <= '0;
      disp_enb <= 1'b0;
      disp_src <= '0;
    end else begin
      if (ctrl_we) begin
        pend_enb <= ctrl_enb;
        if (src_ok) pend_src <= ctrl_src;
      end
      // A write landing on frame_start itself is applied straight away.
      if (frame_start) begin
        disp_enb <= ctrl_we ? ctrl_enb : pend_enb;
        disp_src <= (ctrl_we && src_ok) ? ctrl_src : pend_src;
      end
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_enb <= 1'b0;
      disp_src <= '0;
    end else if (ctrl_we) begin
      disp_enb <= ctrl_enb;
      if (src_ok) disp_src <= ctrl_src;
    end
  end
`endif

  idc_pixel_pipe #(
    .PIX_W (PIX_W),
    .NBUF  (NBUF),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XY_W  (XY_W),
    .ADDR_W(ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .pix_ce    (pix_ce),
    .pix_active(pix_active),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .disp_enb  (disp_enb),
    .disp_src  (disp_src),
    .mem_rdata (mem_rdata),
    .vid_slot  (vid_slot),
    .vid_addr  (vid_addr),
    .pix_out   (pix_out),
    .pix_valid (pix_valid)
  );

  always_comb begin
    mem_en    = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (vid_slot) begin
      mem_en   = NBUF'(1) << disp_src;
      mem_addr = vid_addr;
    end else if (cpu_issue && cpu_ok) begin
      mem_en    = NBUF'(1) << cpu_buf;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      op_we     <= 1'b0;
      op_ok     <= 1'b0;
      op_buf    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          if (cpu_issue) begin
            state     <= ACCESS;
            op_we     <= cpu_we;
            op_ok     <= cpu_ok;
            op_buf    <= cpu_buf;
            cpu_ready <= cpu_we;
          end
        end
        ACCESS: begin
          if (op_we) begin
            state     <= IDLE;
            cpu_ready <= 1'b0;
          end else begin
            state     <= RESP;
            cpu_ready <= 1'b1;
            cpu_rdata <= op_ok ? mem_rdata[int'(op_buf) * PIX_W +: PIX_W] : '0;
          end
        end
        RESP: begin
          state     <= IDLE;
          cpu_ready <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cpu_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_display_controller.sv
// Directed bench for image_display_controller with a behavioural model of three image buffers.
module tb_image_display_controller;

  localparam int PIX_W  = 8;
  localparam int NBUF   = 3;
  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int XY_W   = 10;
  localparam int ADDR_W = 18;
  localparam int BUF_W  = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  pix_ce = 1'b0, pix_active = 1'b0, frame_start = 1'b0;
  logic [XY_W-1:0]       pix_x = '0, pix_y = '0;
  logic                  ctrl_we = 1'b0, ctrl_enb = 1'b0;
  logic [BUF_W-1:0]      ctrl_src = '0;
  logic                  cpu_req = 1'b0, cpu_we = 1'b0;
  logic [BUF_W-1:0]      cpu_buf = '0;
  logic [ADDR_W-1:0]     cpu_addr = '0;
  logic [PIX_W-1:0]      cpu_wdata = '0;
  logic                  cpu_ready;
  logic [PIX_W-1:0]      cpu_rdata;
  logic [NBUF-1:0]       mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [PIX_W-1:0]      mem_wdata;
  logic [NBUF*PIX_W-1:0] mem_rdata;
  logic [PIX_W-1:0]      pix_out;
  logic                  pix_valid;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int ready_cnt = 0;
  int rc0, wc0;
  logic ce_h [32];
  logic act_h [32];
  logic exp_v;

  logic [7:0] bufm [NBUF][IMG_W*IMG_H];
  logic [7:0] rd [NBUF];

  always #5 clk = ~clk;

  image_display_controller #(
    .PIX_W(PIX_W), .NBUF(NBUF), .IMG_W(IMG_W), .IMG_H(IMG_H), .XY_W(XY_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .pix_active(pix_active),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
    .ctrl_we(ctrl_we), .ctrl_src(ctrl_src), .ctrl_enb(ctrl_enb),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_buf(cpu_buf), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_out(pix_out), .pix_valid(pix_valid)
  );

  // Single-port buffers, read-first, one cycle read latency
  assign mem_rdata = {rd[2], rd[1], rd[0]};
  always @(posedge clk) begin
    for (int i = 0; i < NBUF; i++) begin
      if (mem_en[i]) begin
        rd[i] <= bufm[i][mem_addr[15:0]];
        if (mem_we) bufm[i][mem_addr[15:0]] = mem_wdata;
      end
    end
    if (mem_we && (mem_en != '0)) wr_cnt++;
  end

  always @(negedge clk) if (cpu_ready === 1'b1) ready_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic ce, input logic act, input int x, input int y);
    pix_ce     = ce;
    pix_active = act;
    pix_x      = XY_W'(x);
    pix_y      = XY_W'(y);
  endtask

  initial begin
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) begin
        bufm[0][y*IMG_W+x] = 8'(x + y);
        bufm[1][y*IMG_W+x] = 8'(x ^ y);
        bufm[2][y*IMG_W+x] = 8'h00;
      end

    // Reset state
    nxt(); nxt(); #1;
    chk("rst_pix_out", 32'(pix_out), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    nxt(); reset = 1'b1;

    // Display disabled: black everywhere, pix_valid follows pix_active by 2 clocks
    exp_v = 1'b0;
    for (int c = 0; c < 24; c++) begin
      nxt();
      ce_h[c]  = (c % 2 == 0);
      act_h[c] = ((c % 8) < 6);
      pix(ce_h[c], act_h[c], c, 2);
      #1;
      if (c >= 2 && ce_h[c-2]) exp_v = act_h[c-2];
      chk("off_pix_out", 32'(pix_out), 0);
      chk("off_pix_valid", 32'(pix_valid), 32'(exp_v));
      chk("off_mem_en", 32'(mem_en), 0);
    end

    // Display buf1 (x^y)
    nxt(); ctrl_we = 1; ctrl_src = 2'd1; ctrl_enb = 1; pix(1, 1, 5, 3); #1;
    chk("ctrl_cycle_no_slot", 32'(mem_en), 0);
    nxt(); ctrl_we = 0; pix(1, 1, 5, 3); #1;
    chk("slot_mem_en", 32'(mem_en), 32'b010);
    chk("slot_mem_we", 32'(mem_we), 0);
    chk("slot_addr_5_3", 32'(mem_addr), 773);
    nxt(); pix(0, 1, 5, 3); #1;
    chk("lat1_pix_out", 32'(pix_out), 0);
    nxt(); #1;
    chk("pix_5_3", 32'(pix_out), 32'h06);
    chk("pix_5_3_valid", 32'(pix_valid), 1);
    nxt(); pix(1, 1, 10, 7); #1;
    chk("slot_addr_10_7", 32'(mem_addr), 1802);
    nxt(); pix(0, 1, 10, 7); #1;
    chk("lat1_hold", 32'(pix_out), 32'h06);
    nxt(); #1;
    chk("pix_10_7", 32'(pix_out), 32'h0D);
    nxt(); #1;
    chk("pix_hold_no_ce", 32'(pix_out), 32'h0D);
    nxt(); pix(1, 1, 300, 3); #1;
    chk("x300_mem_en", 32'(mem_en), 0);
    nxt(); pix(0, 1, 300, 3);
    nxt(); #1;
    chk("x300_pix_out", 32'(pix_out), 0);
    chk("x300_valid", 32'(pix_valid), 1);
    nxt(); pix(1, 1, 5, 256); #1;
    chk("y256_mem_en", 32'(mem_en), 0);
    nxt(); pix(1, 0, 5, 3); #1;
    chk("inactive_mem_en", 32'(mem_en), 0);
    nxt(); pix(0, 0, 0, 0);
    nxt(); #1;
    chk("inactive_valid", 32'(pix_valid), 0);
    chk("inactive_pix_out", 32'(pix_out), 0);

    // CPU write then read back, buf0 addr 0x100
    rc0 = ready_cnt;
    nxt(); cpu_req = 1; cpu_we = 1; cpu_buf = 0; cpu_addr = 18'h00100; cpu_wdata = 8'hA5; #1;
    chk("wr_mem_en", 32'(mem_en), 32'b001);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h100);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    chk("wr_issue_ready", 32'(cpu_ready), 0);
    nxt(); #1;
    chk("wr_ready", 32'(cpu_ready), 1);
    chk("wr_access_idle_bus", 32'(mem_en), 0);
    cpu_req = 0;
    nxt(); #1;
    chk("wr_ready_drop", 32'(cpu_ready), 0);
    chk("wr_mem_content", 32'(bufm[0][256]), 32'hA5);
    cpu_req = 1; cpu_we = 0; #1;
    chk("rd_mem_en", 32'(mem_en), 32'b001);
    chk("rd_mem_we", 32'(mem_we), 0);
    nxt(); #1;
    chk("rd_access_ready", 32'(cpu_ready), 0);
    nxt(); #1;
    chk("rd_ready", 32'(cpu_ready), 1);
    chk("rd_data", 32'(cpu_rdata), 32'hA5);
    cpu_req = 0;
    nxt(); #1;
    chk("rd_ready_drop", 32'(cpu_ready), 0);
    chk("rd_data_hold", 32'(cpu_rdata), 32'hA5);
    chk("ready_pulses", ready_cnt, rc0 + 2);

    // CPU request contending with active video
    wc0 = wr_cnt;
    nxt(); pix(1, 1, 4, 1); cpu_req = 1; cpu_we = 1; cpu_buf = 2; cpu_addr = 18'h00203; cpu_wdata = 8'h3C; #1;
    chk("contend_video_wins", 32'(mem_en), 32'b010);
    chk("contend_no_we", 32'(mem_we), 0);
    chk("contend_addr", 32'(mem_addr), 260);
    nxt(); pix(0, 1, 4, 1); #1;
    chk("retry_mem_en", 32'(mem_en), 32'b100);
    chk("retry_mem_we", 32'(mem_we), 1);
    chk("retry_addr", 32'(mem_addr), 32'h203);
    chk("retry_ready_low", 32'(cpu_ready), 0);
    nxt(); pix(1, 1, 6, 1); #1;
    chk("retry_ready", 32'(cpu_ready), 1);
    chk("video_in_access", 32'(mem_en), 32'b010);
    chk("pix_4_1", 32'(pix_out), 32'h05);
    cpu_req = 0;
    nxt(); pix(0, 1, 6, 1); #1;
    chk("retry_ready_drop", 32'(cpu_ready), 0);
    chk("pix_4_1_hold", 32'(pix_out), 32'h05);
    nxt(); pix(0, 0, 0, 0); #1;
    chk("pix_6_1", 32'(pix_out), 32'h07);
    chk("buf2_content", 32'(bufm[2][32'h203]), 32'h3C);
    chk("one_write", wr_cnt, wc0 + 1);
    cpu_req = 1; cpu_we = 0; cpu_buf = 3; cpu_addr = 18'h00100; #1;
    chk("badbuf_mem_en", 32'(mem_en), 0);
    nxt(); #1;
    chk("badbuf_access", 32'(cpu_ready), 0);
    nxt(); #1;
    chk("badbuf_ready", 32'(cpu_ready), 1);
    chk("badbuf_rdata", 32'(cpu_rdata), 0);
    cpu_req = 0;
    nxt(); #1;
    chk("badbuf_ready_drop", 32'(cpu_ready), 0);
    wc0 = wr_cnt;
    cpu_req = 1; cpu_we = 1; cpu_buf = 0; cpu_addr = 18'h10000; cpu_wdata = 8'hFF; #1;
    chk("badaddr_mem_en", 32'(mem_en), 0);
    chk("badaddr_mem_we", 32'(mem_we), 0);
    nxt(); #1;
    chk("badaddr_ready", 32'(cpu_ready), 1);
    cpu_req = 0;
    nxt(); #1;
    chk("badaddr_no_write", wr_cnt, wc0);

    // Display source switch
`ifdef IDC_VSYNC_SWAP_EN
    nxt(); ctrl_we = 1; ctrl_src = 2'd0; ctrl_enb = 1; pix(1, 1, 5, 3); #1;
    chk("swap_req_cycle", 32'(mem_en), 32'b010);
    nxt(); ctrl_we = 0; #1;
    chk("swap_pending", 32'(mem_en), 32'b010);
    nxt(); frame_start = 1; #1;
    chk("swap_fs_cycle", 32'(mem_en), 32'b010);
    nxt(); frame_start = 0; #1;
    chk("swap_applied", 32'(mem_en), 32'b001);
    nxt(); ctrl_we = 1; ctrl_src = 2'd1; frame_start = 1; #1;
    chk("swap_coincident_cycle", 32'(mem_en), 32'b001);
    nxt(); ctrl_we = 0; frame_start = 0; #1;
    chk("swap_coincident", 32'(mem_en), 32'b010);
    nxt(); ctrl_we = 1; ctrl_src = 2'd3; frame_start = 1;
    nxt(); ctrl_we = 0; frame_start = 0; #1;
    chk("badsrc_kept", 32'(mem_en), 32'b010);
    pix(0, 0, 0, 0);
`else
    nxt(); ctrl_we = 1; ctrl_src = 2'd0; ctrl_enb = 1; pix(1, 1, 5, 3); #1;
    chk("switch_req_cycle", 32'(mem_en), 32'b010);
    nxt(); ctrl_we = 0; pix(1, 1, 5, 3); #1;
    chk("switch_next_cycle", 32'(mem_en), 32'b001);
    nxt(); pix(0, 1, 5, 3); #1;
    chk("switch_old_pix", 32'(pix_out), 32'h06);
    nxt(); #1;
    chk("switch_new_pix", 32'(pix_out), 32'h08);
    nxt(); ctrl_we = 1; ctrl_src = 2'd3; ctrl_enb = 1; pix(0, 0, 0, 0);
    nxt(); ctrl_we = 0; pix(1, 1, 5, 3); #1;
    chk("badsrc_kept", 32'(mem_en), 32'b001);
    pix(0, 0, 0, 0);
`endif

    // Reset during an access
    nxt(); pix(0, 0, 0, 0); cpu_req = 1; cpu_we = 1; cpu_buf = 0; cpu_addr = 18'h00300; cpu_wdata = 8'h77; #1;
    chk("rstacc_issue", 32'(mem_we), 1);
    nxt(); #1;
    chk("rstacc_in_access", 32'(cpu_ready), 1);
    reset = 1'b0; #1;
    chk("rstacc_ready", 32'(cpu_ready), 0);
    chk("rstacc_mem_we", 32'(mem_we), 0);
    chk("rstacc_mem_en", 32'(mem_en), 0);
    chk("rstacc_pix_out", 32'(pix_out), 0);
    nxt(); cpu_req = 0;
    nxt(); reset = 1'b1; #1;
    rc0 = ready_cnt;
    chk("post_rst_ready", 32'(cpu_ready), 0);
    chk("post_rst_mem_we", 32'(mem_we), 0);
    pix(1, 1, 5, 3); #1;
    chk("post_rst_disp_off", 32'(mem_en), 0);
    nxt(); pix(0, 0, 0, 0); cpu_req = 1; cpu_we = 0; cpu_buf = 0; cpu_addr = 18'h00100;
    nxt(); reset = 1'b0; #1; cpu_req = 0;
    nxt(); reset = 1'b1;
    nxt(); nxt(); #1;
    chk("rd_abort_no_ready", ready_cnt, rc0);
    chk("rd_abort_rdata", 32'(cpu_rdata), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
